// File: rtl/scroll_column_source.sv
// scroll_column_source
// Double-buffered 32x16 column store feeding the 16-row dot-matrix scan driver.
// The host fills the back bank while the scan driver reads the front bank.
// Bank swaps and scroll steps take effect only at the 31 -> 0 wrap of the
// driver's column_id, so a frame is never shown half old and half new.
//
// Optional feature macro: COLUMN_SCROLL_EN
//   defined   : prescaler-driven horizontal scroll via scroll_pos
//   undefined : no scroll logic; scroll_pos is held at 0
module scroll_column_source #(
  parameter int SCROLL_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        swap_req,
  output logic        swap_ack,
  input  logic        scroll_en,
  input  logic [4:0]  column_id,
  output logic [15:0] column_data,
  output logic        LOAD,
  output logic [4:0]  scroll_pos
);

  // Both banks share one array; the top address bit selects the bank.
  logic [15:0] bank_mem [0:63];

  logic        front_sel_q, front_sel_d;
  logic [4:0]  prev_id_q;
  logic        swap_pend_q, swap_pend_d;
  logic        swap_ack_q;
  logic        load_q, load_d;
  logic [15:0] column_data_q;
  logic [4:0]  scroll_pos_q, scroll_pos_d;
  logic        boundary;
  logic        swap_commit;
  logic [5:0]  rd_addr;

  // A frame starts when the driver wraps from the last column back to 0.
  assign boundary = (prev_id_q == 5'd31) && (column_id == 5'd0);

  // Swap request bookkeeping: a request in the boundary cycle itself counts.
  always_comb begin
    swap_commit = boundary && (swap_pend_q || swap_req);
    swap_pend_d = swap_pend_q || swap_req;
    if (swap_commit) begin
      swap_pend_d = 1'b0;
    end
    front_sel_d = front_sel_q ^ swap_commit;
    load_d      = load_q || swap_commit;
  end

  // Swap, LOAD and column-tracking registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      front_sel_q <= 1'b0;
      prev_id_q   <= 5'd0;
      swap_pend_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      front_sel_q <= front_sel_d;
      prev_id_q   <= column_id;
      swap_pend_q <= swap_pend_d;
      swap_ack_q  <= swap_commit;
      load_q      <= load_d;
    end
  end

`ifdef COLUMN_SCROLL_EN
  localparam logic [15:0] PRESC_LAST = 16'(SCROLL_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic        step_pend_q, step_pend_d;
  logic        presc_tc;
  logic        step_commit;

  // Prescaler and step collapse: any number of terminal counts between two
  // boundaries produce exactly one step at the next boundary.
  always_comb begin
    presc_tc = scroll_en && (presc_q == PRESC_LAST);
    presc_d  = presc_q;
    if (scroll_en) begin
      presc_d = presc_tc ? 16'd0 : presc_q + 16'd1;
    end
    step_commit  = boundary && (step_pend_q || presc_tc);
    step_pend_d  = (step_pend_q || presc_tc) && !step_commit;
    scroll_pos_d = scroll_pos_q + {4'd0, step_commit};
  end

  // Scroll state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q      <= 16'd0;
      step_pend_q  <= 1'b0;
      scroll_pos_q <= 5'd0;
    end else begin
      presc_q      <= presc_d;
      step_pend_q  <= step_pend_d;
      scroll_pos_q <= scroll_pos_d;
    end
  end
`else
  // Scroll inputs have no effect in this build.
  logic unused_scroll_cfg;
  assign unused_scroll_cfg = scroll_en & (SCROLL_DIV != 0);
  assign scroll_pos_d      = 5'd0;
  assign scroll_pos_q      = 5'd0;
`endif

  // Read through next-state bank/offset so the boundary read already sees the
  // newly committed frame; the 5-bit sum wraps around the 32 columns.
  assign rd_addr = {front_sel_d, column_id + scroll_pos_d};

  // Host writes always land in the bank that is back before this edge.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      bank_mem[{~front_sel_q, wr_addr}] <= wr_data;
    end
  end

  // Registered read port toward the scan driver.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      column_data_q <= 16'h0000;
    end else begin
      column_data_q <= bank_mem[rd_addr];
    end
  end

  assign column_data = column_data_q;
  assign swap_ack    = swap_ack_q;
  assign LOAD        = load_q;
  assign scroll_pos  = scroll_pos_q;

endmodule

// File: tb/tb_scroll_column_source.sv
// Self-checking bench for scroll_column_source: a frame-level reference model
// checked every cycle, plus directed literal expectations.
// Honors COLUMN_SCROLL_EN the same way the design does.
module tb_scroll_column_source;

  localparam int DIV = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        swap_req;
  logic        swap_ack;
  logic        scroll_en;
  logic [4:0]  column_id;
  logic [15:0] column_data;
  logic        LOAD;
  logic [4:0]  scroll_pos;

  scroll_column_source #(.SCROLL_DIV(DIV)) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .scroll_en(scroll_en), .column_id(column_id), .column_data(column_data),
    .LOAD(LOAD), .scroll_pos(scroll_pos)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
    $display("[tb] %s actual=%h expected=%h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_mem   [2][32];
  bit          m_known [2][32];
  int  m_front, m_prev, m_pos, m_presc;
  bit  m_swp, m_step, m_ack, m_load, m_valid, m_dknown;
  logic [15:0] m_data;

  initial begin
    m_valid = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++) m_known[b][a] = 0;
  end

  always @(posedge CLK) begin
    bit bnd, do_swap, do_step, tc;
    int back, ra;
    if (RESET) begin
      m_front = 0; m_prev = 0; m_pos = 0; m_presc = 0;
      m_swp = 0; m_step = 0; m_ack = 0; m_load = 0;
      m_data = 16'h0000; m_dknown = 1; m_valid = 1;
    end else if (m_valid) begin
      back    = 1 - m_front;
      bnd     = (m_prev == 31) && (column_id == 0);
      do_swap = bnd && (m_swp || swap_req);
      m_swp   = do_swap ? 0 : (m_swp || swap_req);
      do_step = 0;
`ifdef COLUMN_SCROLL_EN
      tc = scroll_en && (m_presc == DIV - 1);
      if (scroll_en) m_presc = (m_presc + 1) % DIV;
      do_step = bnd && (m_step || tc);
      m_step  = do_step ? 0 : (m_step || tc);
`else
      tc = 0;
`endif
      if (do_step) m_pos = (m_pos + 1) % 32;
      if (do_swap) begin
        m_front = 1 - m_front;
        m_load  = 1;
      end
      m_ack    = do_swap;
      ra       = (int'(column_id) + m_pos) % 32;
      m_data   = m_mem[m_front][ra];
      m_dknown = m_known[m_front][ra];
      if (wr_en) begin
        m_mem[back][wr_addr]   = wr_data;
        m_known[back][wr_addr] = 1;
      end
      m_prev = int'(column_id);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_swap_ack", {31'd0, swap_ack}, {31'd0, m_ack});
      chk("model_load", {31'd0, LOAD}, {31'd0, m_load});
      chk("model_scroll_pos", {27'd0, scroll_pos}, 32'(m_pos));
      if (m_dknown) chk("model_column_data", {16'd0, column_data}, {16'd0, m_data});
    end
    if (swap_ack === 1'b1) ack_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic sweep(input int frames);
    for (int f = 0; f < frames; f++)
      for (int c = 0; c < 32; c++) begin
        column_id = 5'(c);
        @(negedge CLK);
      end
  endtask

  task automatic read_col(input int c, input logic [15:0] exp, input string name);
    column_id = 5'(c);
    @(negedge CLK);
    dchk(name, {16'd0, column_data}, {16'd0, exp});
  endtask

  task automatic write_back(input int a, input logic [15:0] d);
    wr_en = 1; wr_addr = 5'(a); wr_data = d;
    @(negedge CLK);
    wr_en = 0;
  endtask

  task automatic pulse_swap();
    swap_req = 1;
    @(negedge CLK);
    swap_req = 0;
  endtask

  int a0;

  initial begin
    RESET = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    swap_req = 0; scroll_en = 0; column_id = 0;
    repeat (2) @(negedge CLK);
    RESET = 0;
    dchk("reset_column_data", {16'd0, column_data}, 32'h0);
    dchk("reset_load", {31'd0, LOAD}, 32'h0);
    dchk("reset_swap_ack", {31'd0, swap_ack}, 32'h0);
    dchk("reset_scroll_pos", {27'd0, scroll_pos}, 32'h0);

    // Fill back bank (bank 1), two requests that must collapse into one swap.
    for (int i = 0; i < 32; i++) write_back(i, 16'hA000 + 16'(i));
    pulse_swap();
    @(negedge CLK);
    pulse_swap();
    a0 = ack_cnt;
    sweep(3);
    dchk("swap_once", 32'(ack_cnt - a0), 32'd1);
    dchk("load_after_swap", {31'd0, LOAD}, 32'h1);
    read_col(5, 16'hA005, "front_col5");

    // Back-bank isolation, then second swap exposes the new data.
    write_back(5, 16'h1234);
    read_col(5, 16'hA005, "isolation_col5");
    pulse_swap();
    a0 = ack_cnt;
    sweep(2);
    dchk("second_swap_ack", 32'(ack_cnt - a0), 32'd1);
    read_col(5, 16'h1234, "after_swap2_col5");

    // Third swap back to the A pattern, then fill the other bank with B.
    pulse_swap();
    sweep(2);
    read_col(7, 16'hA007, "after_swap3_col7");
    for (int i = 0; i < 32; i++) write_back(i, 16'hB000 + 16'(i));

`ifdef COLUMN_SCROLL_EN
    // Two terminal counts outside any frame collapse into one step.
    scroll_en = 1;
    repeat (8) @(negedge CLK);
    scroll_en = 0;
    sweep(1);
    read_col(0, 16'hA001, "boundary_read_pos1");
    dchk("scroll_pos_1", {27'd0, scroll_pos}, 32'd1);
    read_col(31, 16'hA000, "col31_wraps_to_0");
    scroll_en = 1;
    sweep(32);
    dchk("scroll_pos_wrap", {27'd0, scroll_pos}, 32'd0);
    scroll_en = 0;
`endif

    // Swap and (when present) a pending step commit at the same boundary.
    swap_req = 1; column_id = 5'd31;
    @(negedge CLK);
    swap_req = 0; column_id = 5'd0;
    @(negedge CLK);
    dchk("simul_swap_ack", {31'd0, swap_ack}, 32'h1);
`ifdef COLUMN_SCROLL_EN
    dchk("simul_scroll_pos", {27'd0, scroll_pos}, 32'd1);
    dchk("simul_first_read", {16'd0, column_data}, 32'h0000B001);
`else
    dchk("simul_scroll_pos", {27'd0, scroll_pos}, 32'd0);
    dchk("simul_first_read", {16'd0, column_data}, 32'h0000B000);
`endif
    @(negedge CLK);
    dchk("swap_ack_one_cycle", {31'd0, swap_ack}, 32'h0);

    // Reset while a swap is pending discards it.
    pulse_swap();
    RESET = 1;
    repeat (2) @(negedge CLK);
    RESET = 0;
    dchk("rst_mid_load", {31'd0, LOAD}, 32'h0);
    a0 = ack_cnt;
    sweep(2);
    dchk("rst_mid_no_ack", 32'(ack_cnt - a0), 32'd0);
    dchk("rst_mid_load_after", {31'd0, LOAD}, 32'h0);
    dchk("rst_mid_scroll_pos", {27'd0, scroll_pos}, 32'd0);
    read_col(3, 16'hB003, "rst_mid_front_bank0");

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scroll_column_source.md
# scroll_column_source

Upstream column feeder for the 16-row dot-matrix scan driver. It holds two 32×16 column banks. The host fills the back bank through a write port while the scan driver reads the front bank by column index. Bank swaps and horizontal scroll steps are committed only at scan-frame boundaries, so the display never tears. Its `column_data` and `LOAD` outputs drive the scan driver's `in_column` and `LOAD` inputs; the driver's `column_id` comes back in.

## Interface
- `SCROLL_DIV`, default 50000: CLK cycles per scroll step. Legal range is 2..65535.
- `CLK`  in  1  system clock. The only clock.
- `RESET`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  write strobe into the back bank.
- `wr_addr`  in  5  back-bank column address.
- `wr_data`  in  16  column pattern; bit n is row n.
- `swap_req`  in  1  one-cycle pulse requesting a front/back swap.
- `swap_ack`  out  1  one-cycle pulse when the swap commits.
- `scroll_en`  in  1  enables the scroll prescaler.
- `column_id`  in  5  column currently requested by the scan driver.
- `column_data`  out  16  front-bank pattern for the requested, scrolled column.
- `LOAD`  out  1  display enable; goes high after the first swap.
- `scroll_pos`  out  5  current scroll offset.

## Operation
- **Storage:** two banks, 32×16 each. Register `front_sel` selects the front bank. Memory contents are not reset.
- **Writes:** when `wr_en` is high, write `back[wr_addr] <= wr_data`. A write in the same cycle as a swap commit goes to the pre-swap back bank, which becomes front on that same edge.
- **Read:** `column_data <= front[(column_id + scroll_pos) mod 32]`, registered. The sum wraps at 5 bits.
- **Frame boundary:** `prev_id` is a registered copy of `column_id`. A boundary is the cycle where `prev_id == 31` and `column_id == 0`.
- **Swap:**
  - `swap_req` sets `swap_pend`.
  - At a boundary with `swap_pend` set: toggle `front_sel`, clear `swap_pend`, and pulse `swap_ack` on the next cycle.
  - A second `swap_req` while one is pending is absorbed; only one swap occurs.
  - `swap_req` arriving in the boundary cycle itself is committed at that boundary.
- **LOAD:** set on the first swap commit. Stays high until RESET.
- **Scroll:**
  - While `scroll_en` is high, 16-bit `presc` counts 0..SCROLL_DIV-1 and then wraps. Reaching the terminal count sets `step_pend`.
  - At a boundary with `step_pend` set: `scroll_pos <= scroll_pos + 1` (31 wraps to 0), and clear `step_pend`.
  - Several terminal counts before one boundary collapse into a single step.
  - When `scroll_en` is low, `presc` holds its value; a pending step still commits.
- **Simultaneous events:** a swap and a step at the same boundary both commit. The new bank and the new offset take effect together for the first read of the next frame.

## Timing
- Read latency is 1 cycle from `column_id` to `column_data`.
- A swap or step commits on the edge that ends the boundary cycle. The read issued in the boundary cycle (`column_id` = 0) already uses the new bank and offset. `swap_ack` is high in the cycle after the commit.
- Reset values:
  - Outputs: `column_data` = 16'h0000, `swap_ack` = 0, `LOAD` = 0, `scroll_pos` = 0.
  - Internal state: `front_sel` = 0, `presc` = 0, `prev_id` = 0, `swap_pend` = 0, `step_pend` = 0.
- RESET mid-operation discards pending swaps and steps and drops `LOAD` in the next cycle. Bank contents are retained.

## Configuration
- Macro: `COLUMN_SCROLL_EN`.
- **Defined:** prescaler, `step_pend` and scroll offset are present, as described above.
- **Undefined:** no prescaler or step logic; `scroll_pos` is tied to 0; `scroll_en` and `SCROLL_DIV` are ignored. Read address = `column_id`. Swap behaviour is unchanged.

## Test plan
- **Reset:** assert RESET for 2 cycles → `column_data` = 0, `LOAD` = 0, `swap_ack` = 0, `scroll_pos` = 0.
- **Fill and swap:** write `back[i]` = 16'hA000+i for i = 0..31, pulse `swap_req`, then sweep `column_id` 0..31 repeatedly → `swap_ack` pulses once, 1 cycle after the first 31→0 boundary. `LOAD` = 1. `column_id` = 5 gives `column_data` = 16'hA005 one cycle later.
- **Back-bank isolation:** after the swap, write `back[5]` = 16'h1234 → `column_id` = 5 still reads 16'hA005. After a second swap, it reads 16'h1234.
- **Scroll wrap (`COLUMN_SCROLL_EN`, SCROLL_DIV = 4):** with `scroll_en` = 1 and `column_id` 0..31 repeatedly → `scroll_pos` increments once per boundary. At `scroll_pos` = 1, `column_id` = 31 reads 16'hA000. `scroll_pos` goes 31 → 0.
- **Simultaneous commit:** `swap_req` and a step pending at the same boundary → `swap_ack` pulses, `scroll_pos` increments, and the first read of the frame returns `new_front[(0 + new_pos) mod 32]`.
- **Reset mid-pending:** pulse `swap_req`, then assert RESET before any boundary → no `swap_ack`, `LOAD` = 0, `scroll_pos` = 0, `front_sel` unchanged at 0.
